tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//   Shared time-base controller for the 50 MHz domain. Serves NumChannels independent rate channels.
//   Each channel produces a one-cycle tick and a square-wave phase output at a programmable period.
//   Channels are started, stopped, one-shot fired and re-periodised through one valid/ready command port.
//   Sits between the control logic (buttons/FSMs) and the counters and displays that consume slow rates.
// PARAMETERS
//   NumChannels    4           number of rate channels, 1..16
//   DefaultPeriod  25_000_000  reset period in clock cycles (1 Hz phase square wave at 50 MHz)
//   PeriodW        32          width of period registers and counters
// PORTS
//   i_clock_50mhz  in   1            system clock, 50 MHz
//   i_reset        in   1            asynchronous, active-high reset
//   i_cmd_valid    in   1            command present
//   o_cmd_ready    out  1            command can be accepted this cycle
//   i_cmd_op       in   3            0 NOP, 1 START, 2 STOP, 3 ONESHOT, 4 RESYNC, 5 SET_PERIOD
//   i_cmd_chan     in   ChanW        target channel; ChanW = max(1,$clog2(NumChannels))
//   i_cmd_period   in   PeriodW      period for SET_PERIOD, in clock cycles
//   o_cmd_err      out  1            one-cycle pulse: command rejected
//   o_tick         out  NumChannels  one-cycle pulse per elapsed period
//   o_phase        out  NumChannels  toggles on every tick (square wave, half-period = period)
//   o_active       out  NumChannels  channel is in RUN or ONESHOT
// BEHAVIOUR
//   Reset (async, on assertion): o_cmd_ready=0, o_cmd_err=0, o_tick=0, o_phase=0, o_active=0;
//     all channels OFF, counters 0, period and shadow period = DefaultPeriod. o_cmd_ready=1 on first edge after release.
//   Command path, 2-state FSM: ACCEPT (ready=1) -> APPLY (ready=0) -> ACCEPT.
//     valid&ready at edge k latches op/chan/period. The command takes effect at edge k+1. Max one command per 2 cycles.
//     Invalid op (6,7), chan>=NumChannels, or SET_PERIOD with period 0: no state change, o_cmd_err high the cycle after k+1.
//     NOP is accepted with no effect and no error.
//   Channel states: OFF, RUN, ONESHOT.
//     START: OFF->RUN, counter=0. In RUN or ONESHOT it is ignored (no error, counter untouched).
//     ONESHOT: OFF->ONESHOT, counter=0. After one tick -> OFF. In RUN or ONESHOT it is ignored.
//     STOP: any->OFF, counter=0. o_phase holds its value.
//     RESYNC: counter=0, state unchanged.
//     SET_PERIOD: writes the shadow period. In OFF it copies to the active period at the apply edge.
//       Otherwise it copies at the next counter wrap, so the current period finishes at the old length.
//   Counting, RUN or ONESHOT: counter increments each cycle. At counter==period-1 the counter wraps to 0.
//     On wrap, o_tick is registered high for exactly one cycle and o_phase toggles.
//     With period P applied at edge a, o_tick is high in the cycle after edge a+P-1, then every P cycles.
//   Period 1: o_tick is high every cycle while running and o_phase toggles every cycle.
//   Command vs wrap in the same cycle: the wrap is evaluated on pre-command state, so the tick is emitted.
//     The command then applies. Example: STOP on a wrap cycle still yields that tick, then OFF.
//   No channel interacts with another. All channels may tick in the same cycle.
//   Reset mid-operation: state is discarded immediately and the reset values above apply. Pending commands are lost.
//   o_active = (state != OFF), registered.
// STRUCTURE
//   Package tick_sched_pkg: cmd_op_e enum (values above), chan_state_e {OFF,RUN,ONESHOT}, cmd_fsm_e {ACCEPT,APPLY},
//     and the localparam for the period width default.
//   Sub-module tick_channel: one channel (state, counter, active/shadow period, tick/phase). Instantiated per channel by a generate loop.
//   Top level: command FSM, decode/validation, per-channel apply strobe, output concatenation.
// TESTING
//   1 Reset, then START ch0 with DefaultPeriod overridden to 4 -> o_tick[0] high every 4 cycles; o_phase[0] toggles on each tick.
//   2 SET_PERIOD ch1=3 while OFF, then ONESHOT ch1 -> exactly one o_tick[1] 3 cycles after apply, then o_active[1]=0.
//   3 ch0 RUN at period 8. At counter=5, SET_PERIOD 2 -> next tick at the old 8-cycle boundary, then ticks every 2 cycles.
//   4 STOP timed to land on a wrap cycle -> that tick is emitted, then no ticks; o_phase frozen; o_active=0.
//   5 chan=NumChannels, op=7, and SET_PERIOD 0 -> o_cmd_err pulse for each; channel registers unchanged.
//   6 Back-to-back valid -> o_cmd_ready low in every APPLY cycle.
//     Async reset asserted mid-count -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler and its rate channels.
package tick_sched_pkg;

    localparam int PERIOD_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_START      = 3'd1,
        OP_STOP       = 3'd2,
        OP_ONESHOT    = 3'd3,
        OP_RESYNC     = 3'd4,
        OP_SET_PERIOD = 3'd5
    } cmd_op_e;

    typedef enum logic [1:0] {
        CH_OFF,
        CH_RUN,
        CH_ONESHOT
    } chan_state_e;

    typedef enum logic {
        ST_ACCEPT,
        ST_APPLY
    } cmd_fsm_e;

    // Opcodes 6 and 7 are unassigned and get rejected.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One rate channel: run state, cycle counter, active/shadow period,
// registered tick pulse, phase square wave and active flag.
//
// The tick register looks ahead: it is loaded on the edge where the counter
// reaches period-1, so the pulse is visible during the cycle whose end is
// the wrap edge. A period started at edge a therefore ticks in the cycle
// after edge a+P-1, and a period of 1 ticks every running cycle.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PeriodW       = PERIOD_W_DEF,
    parameter int DefaultPeriod = 25_000_000
) (
    input  logic               i_clock_50mhz,
    input  logic               i_reset,
    input  logic               i_apply,
    input  cmd_op_e            i_op,
    input  logic [PeriodW-1:0] i_period,
    output logic               o_tick,
    output logic               o_phase,
    output logic               o_active
);

    localparam logic [PeriodW-1:0] ONE      = PeriodW'(1);
    localparam logic [PeriodW-1:0] RST_PER  = PeriodW'(DefaultPeriod);

    chan_state_e        r_state,  w_state_nxt;
    logic [PeriodW-1:0] r_cnt,    w_cnt_nxt;
    logic [PeriodW-1:0] r_period, w_period_nxt;
    logic [PeriodW-1:0] r_shadow, w_shadow_nxt;
    logic               r_tick,   w_tick_nxt;
    logic               r_phase;
    logic               r_active;
    logic               w_running;
    logic               w_wrap;

    assign w_running = (r_state != CH_OFF);
    assign w_wrap    = w_running && (r_cnt == r_period - ONE);

    // Next state: counting/wrap on the pre-command state first, then the command on top.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_shadow_nxt = r_shadow;

        if (w_running) begin
            if (w_wrap) begin
                w_cnt_nxt    = '0;
                w_period_nxt = r_shadow;
                if (r_state == CH_ONESHOT) begin
                    w_state_nxt = CH_OFF;
                end
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end

        if (i_apply) begin
            case (i_op)
                OP_START: begin
                    if (w_state_nxt == CH_OFF) begin
                        w_state_nxt = CH_RUN;
                        w_cnt_nxt   = '0;
                    end
                end
                OP_ONESHOT: begin
                    if (w_state_nxt == CH_OFF) begin
                        w_state_nxt = CH_ONESHOT;
                        w_cnt_nxt   = '0;
                    end
                end
                OP_STOP: begin
                    w_state_nxt = CH_OFF;
                    w_cnt_nxt   = '0;
                end
                OP_RESYNC: begin
                    w_cnt_nxt = '0;
                end
                OP_SET_PERIOD: begin
                    // A running channel finishes its current period at the old length.
                    w_shadow_nxt = i_period;
                    if (w_state_nxt == CH_OFF) begin
                        w_period_nxt = i_period;
                    end
                end
                default: ;
            endcase
        end

        w_tick_nxt = (w_state_nxt != CH_OFF) && (w_cnt_nxt == w_period_nxt - ONE);
    end

    // Channel state and output registers.
    always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= CH_OFF;
            r_cnt    <= '0;
            r_period <= RST_PER;
            r_shadow <= RST_PER;
            r_tick   <= 1'b0;
            r_phase  <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_shadow <= w_shadow_nxt;
            r_tick   <= w_tick_nxt;
            r_phase  <= r_phase ^ w_tick_nxt;
            r_active <= (w_state_nxt != CH_OFF);
        end
    end

    assign o_tick   = r_tick;
    assign o_phase  = r_phase;
    assign o_active = r_active;

endmodule

// File: rtl/tick_scheduler.sv
// Shared time-base controller: a valid/ready command port feeding a bank of
// independent rate channels. Commands are latched in ACCEPT and applied to
// the addressed channel during the following APPLY cycle.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int NumChannels   = 4,
    parameter  int DefaultPeriod = 25_000_000,
    parameter  int PeriodW       = PERIOD_W_DEF,
    localparam int ChanW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   i_clock_50mhz,
    input  logic                   i_reset,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [2:0]             i_cmd_op,
    input  logic [ChanW-1:0]       i_cmd_chan,
    input  logic [PeriodW-1:0]     i_cmd_period,
    output logic                   o_cmd_err,
    output logic [NumChannels-1:0] o_tick,
    output logic [NumChannels-1:0] o_phase,
    output logic [NumChannels-1:0] o_active
);

    cmd_fsm_e               r_fsm, w_fsm_nxt;
    logic                   r_ready;
    logic                   r_err;
    logic [2:0]             r_cmd_op;
    logic [ChanW-1:0]       r_cmd_chan;
    logic [PeriodW-1:0]     r_cmd_period;
    logic                   w_accept;
    logic                   w_cmd_ok;
    logic                   w_chan_ok;
    logic                   w_apply_any;
    logic                   w_err_nxt;
    cmd_op_e                w_op;
    logic [NumChannels-1:0] w_apply;

    assign w_accept  = i_cmd_valid && r_ready;
    assign w_chan_ok = (32'(r_cmd_chan) < NumChannels);
    assign w_cmd_ok  = op_is_valid(r_cmd_op) && w_chan_ok &&
                       !((r_cmd_op == 3'(OP_SET_PERIOD)) && (r_cmd_period == '0));
    assign w_op      = cmd_op_e'(r_cmd_op);

    // Command FSM state register.
    always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
        if (i_reset) begin
            r_fsm <= ST_ACCEPT;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Command FSM next state, apply strobe and error decision.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_apply_any = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_fsm)
            ST_ACCEPT: begin
                if (w_accept) begin
                    w_fsm_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_fsm_nxt   = ST_ACCEPT;
                w_apply_any = w_cmd_ok;
                w_err_nxt   = !w_cmd_ok;
            end
            default: w_fsm_nxt = ST_ACCEPT;
        endcase
    end

    // Ready and error are registered so both read 0 while reset is held.
    always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
        if (i_reset) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= (w_fsm_nxt == ST_ACCEPT);
            r_err   <= w_err_nxt;
        end
    end

    // Capture the command fields on handshake.
    always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
        if (i_reset) begin
            r_cmd_op     <= '0;
            r_cmd_chan   <= '0;
            r_cmd_period <= '0;
        end else if (w_accept) begin
            r_cmd_op     <= i_cmd_op;
            r_cmd_chan   <= i_cmd_chan;
            r_cmd_period <= i_cmd_period;
        end
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        assign w_apply[g] = w_apply_any && (32'(r_cmd_chan) == g);

        tick_channel #(
            .PeriodW       (PeriodW),
            .DefaultPeriod (DefaultPeriod)
        ) u_chan (
            .i_clock_50mhz (i_clock_50mhz),
            .i_reset       (i_reset),
            .i_apply       (w_apply[g]),
            .i_op          (w_op),
            .i_period      (r_cmd_period),
            .o_tick        (o_tick[g]),
            .o_phase       (o_phase[g]),
            .o_active      (o_active[g])
        );
    end

    assign o_cmd_ready = r_ready;
    assign o_cmd_err   = r_err;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: 3 channels, default period 4.
module tb_tick_scheduler;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_op;
    logic [1:0]  i_cmd_chan;
    logic [15:0] i_cmd_period;
    logic        o_cmd_err;
    logic [2:0]  o_tick;
    logic [2:0]  o_phase;
    logic [2:0]  o_active;

    int n_assert = 0;
    int n_fail   = 0;

    tick_scheduler #(
        .NumChannels   (3),
        .DefaultPeriod (4),
        .PeriodW       (16)
    ) dut (
        .i_clock_50mhz (clk),
        .i_reset       (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_chan    (i_cmd_chan),
        .i_cmd_period  (i_cmd_period),
        .o_cmd_err     (o_cmd_err),
        .o_tick        (o_tick),
        .o_phase       (o_phase),
        .o_active      (o_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [1:0] ch, input logic [15:0] per);
        int waitc = 0;
        while (o_cmd_ready !== 1'b1 && waitc < 20) begin
            cyc();
            waitc++;
        end
        check("cmd_ready_before_send", 32'(o_cmd_ready), 32'd1);
        i_cmd_valid  = 1'b1;
        i_cmd_op     = op;
        i_cmd_chan   = ch;
        i_cmd_period = per;
        cyc();
        i_cmd_valid  = 1'b0;
        check("ready_low_in_apply", 32'(o_cmd_ready), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        i_cmd_valid  = 1'b0;
        i_cmd_op     = 3'd0;
        i_cmd_chan   = 2'd0;
        i_cmd_period = 16'd0;

        // Reset state
        repeat (2) cyc();
        check("rst_ready",  32'(o_cmd_ready), 32'd0);
        check("rst_err",    32'(o_cmd_err),   32'd0);
        check("rst_tick",   32'(o_tick),      32'd0);
        check("rst_phase",  32'(o_phase),     32'd0);
        check("rst_active", 32'(o_active),    32'd0);
        rst = 1'b0;
        check("ready_before_first_edge", 32'(o_cmd_ready), 32'd0);
        cyc();
        check("ready_after_release", 32'(o_cmd_ready), 32'd1);

        // 1: START ch0 at default period 4
        send(3'd1, 2'd0, 16'd0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            check($sformatf("t1_tick0_%0d", i),   32'(o_tick[0]),   32'((i % 4) == 3));
            check($sformatf("t1_phase0_%0d", i),  32'(o_phase[0]),  32'(((i + 1) / 4) % 2));
            check($sformatf("t1_active0_%0d", i), 32'(o_active[0]), 32'd1);
        end

        // 2: SET_PERIOD ch1=3 while OFF, then ONESHOT
        send(3'd5, 2'd1, 16'd3);
        send(3'd3, 2'd1, 16'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("t2_tick1_%0d", i),   32'(o_tick[1]),   32'(i == 2));
            check($sformatf("t2_active1_%0d", i), 32'(o_active[1]), 32'(i <= 2));
            check($sformatf("t2_phase1_%0d", i),  32'(o_phase[1]),  32'(i >= 2));
        end

        // 3: ch0 at period 8, SET_PERIOD 2 landing at counter 5
        send(3'd2, 2'd0, 16'd0);
        send(3'd5, 2'd0, 16'd8);
        send(3'd1, 2'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("t3_tick0_%0d", i), 32'(o_tick[0]), 32'd0);
        end
        send(3'd5, 2'd0, 16'd2);
        check("t3_tick0_5", 32'(o_tick[0]), 32'd0);
        for (int i = 6; i < 12; i++) begin
            cyc();
            check($sformatf("t3_tick0_%0d", i), 32'(o_tick[0]), 32'(i == 7 || i == 9 || i == 11));
        end

        // 4: ch2 period 3, STOP applied during its third tick cycle
        send(3'd5, 2'd2, 16'd3);
        send(3'd1, 2'd2, 16'd0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("t4_tick2_%0d", i), 32'(o_tick[2]), 32'(i == 2 || i == 5));
        end
        send(3'd2, 2'd2, 16'd0);
        check("t4_wrap_tick2",   32'(o_tick[2]),   32'd1);
        check("t4_wrap_phase2",  32'(o_phase[2]),  32'd1);
        check("t4_wrap_active2", 32'(o_active[2]), 32'd1);
        for (int i = 9; i < 13; i++) begin
            cyc();
            check($sformatf("t4_stop_tick2_%0d", i),   32'(o_tick[2]),   32'd0);
            check($sformatf("t4_stop_phase2_%0d", i),  32'(o_phase[2]),  32'd1);
            check($sformatf("t4_stop_active2_%0d", i), 32'(o_active[2]), 32'd0);
        end

        // 5: rejected commands
        send(3'd1, 2'd3, 16'd0);
        check("t5_chan_err_early", 32'(o_cmd_err), 32'd0);
        cyc();
        check("t5_chan_err", 32'(o_cmd_err), 32'd1);
        cyc();
        check("t5_chan_err_clear", 32'(o_cmd_err), 32'd0);
        send(3'd7, 2'd1, 16'd0);
        cyc();
        check("t5_op7_err", 32'(o_cmd_err), 32'd1);
        cyc();
        check("t5_op7_err_clear", 32'(o_cmd_err), 32'd0);
        send(3'd5, 2'd1, 16'd0);
        cyc();
        check("t5_per0_err", 32'(o_cmd_err), 32'd1);
        check("t5_per0_active1", 32'(o_active[1]), 32'd0);
        send(3'd0, 2'd1, 16'd0);
        cyc();
        check("t5_nop_err", 32'(o_cmd_err), 32'd0);
        send(3'd3, 2'd1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("t5_kept_tick1_%0d", i),   32'(o_tick[1]),   32'(i == 2));
            check($sformatf("t5_kept_active1_%0d", i), 32'(o_active[1]), 32'(i <= 2));
        end

        // 6: back-to-back valid, ready alternates
        check("t6_ready_start", 32'(o_cmd_ready), 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_op    = 3'd0;
        i_cmd_chan  = 2'd0;
        for (int j = 0; j < 6; j++) begin
            cyc();
            check($sformatf("t6_ready_%0d", j), 32'(o_cmd_ready), 32'(j % 2));
            check($sformatf("t6_err_%0d", j),   32'(o_cmd_err),   32'd0);
        end
        i_cmd_valid = 1'b0;

        // Async reset mid-count
        check("pre_rst_active0", 32'(o_active[0]), 32'd1);
        check("pre_rst_phase2",  32'(o_phase[2]),  32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_tick",   32'(o_tick),      32'd0);
        check("arst_phase",  32'(o_phase),     32'd0);
        check("arst_active", 32'(o_active),    32'd0);
        check("arst_ready",  32'(o_cmd_ready), 32'd0);
        check("arst_err",    32'(o_cmd_err),   32'd0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        check("arst_ready_back", 32'(o_cmd_ready), 32'd1);
        send(3'd1, 2'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("arst_default_tick0_%0d", i), 32'(o_tick[0]), 32'(i == 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
